bpfcap_dma_engine: RTL

Parametrised successor of the single-shot capture datapath. It accepts queued packet descriptors (source begin/end, destination base) over an Avalon-MM CSR slave. For each descriptor it copies the packet from source memory to destination memory using a burst read master, an internal FIFO and a burst write master. It counts completed packets and bytes, and raises a maskable interrupt on completion. It sits between the HPS-mapped register window and the SDRAM/HPS bridges.

---
 rtl/bpfcap_dma_engine.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/bpfcap_dma_engine.sv
// Descriptor-queued memory-to-memory copy engine: CSR slave, burst read master,
// data FIFO and burst write master, with completion counters and a maskable irq.
module bpfcap_dma_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BURST_MAX  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int DESC_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_s0_address,
  input  logic              avs_s0_write,
  input  logic [31:0]       avs_s0_writedata,
  input  logic              avs_s0_read,
  output logic [31:0]       avs_s0_readdata,
  output logic [ADDR_W-1:0] avs_m0_address,
  output logic              avs_m0_read,
  output logic [15:0]       avs_m0_burstcount,
  input  logic              avs_m0_waitrequest,
  input  logic [DATA_W-1:0] avs_m0_readdata,
  input  logic              avs_m0_readdatavalid,
  output logic [ADDR_W-1:0] avs_m1_address,
  output logic              avs_m1_write,
  output logic [DATA_W-1:0] avs_m1_writedata,
  output logic [15:0]       avs_m1_burstcount,
  input  logic              avs_m1_waitrequest,
  output logic              irq
);
  localparam int SH = $clog2(DATA_W / 8);
  localparam int FA = $clog2(FIFO_DEPTH);
  localparam int FW = FA + 1;
  localparam int QA = $clog2(DESC_DEPTH);
  localparam int QW = QA + 1;
  localparam logic [QW-1:0] QFULL = QW'(DESC_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, XFER = 2'd2, DONE = 2'd3} state_t;
  typedef struct packed {logic [31:0] src; logic [31:0] lim; logic [31:0] dst;} desc_t;

  state_t state, state_nx;
  logic load, done, busy;
  logic enable, irq_en, clr_pend, overflow, irq_pending, clr_now;
  logic [31:0] src_begin, src_end, dst_base, done_count, bytes_done;

  desc_t q_mem [DESC_DEPTH];
  desc_t head;
  logic [QA-1:0] q_wp, q_rp;
  logic [QW-1:0] q_cnt;
  logic q_full, q_empty, push_req, push, pop;

  logic [DATA_W-1:0] f_mem [FIFO_DEPTH];
  logic [FA-1:0] f_wp, f_rp;
  logic [FW-1:0] f_used, outstanding;
  logic [31:0] cur_beats, rd_rem, wr_rem, wr_left, credit, rd_len, wr_len, beats;
  logic rd_go, rd_acc, wr_go, wr_beat, rvalid;

  assign head     = q_mem[q_rp];
  assign beats    = (head.lim - head.src) >> SH;
  assign q_full   = (q_cnt == QFULL);
  assign q_empty  = (q_cnt == '0);
  assign push_req = avs_s0_write && avs_s0_address == 3'd2 && avs_s0_writedata > src_begin;
  assign pop      = done;
  assign push     = push_req && (!q_full || pop);
  assign clr_now  = clr_pend && state == IDLE;
  assign rd_acc   = avs_m0_read && !avs_m0_waitrequest;
  assign wr_beat  = avs_m1_write && !avs_m1_waitrequest;
  // beats arriving after a reset abandoned their burst are ignored
  assign rvalid   = avs_m0_readdatavalid && outstanding != '0;
  assign avs_m1_writedata = avs_m1_write ? f_mem[f_rp] : '0;
  assign irq = irq_pending & irq_en;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (enable && !q_empty && !clr_pend) state_nx = LOAD;
      LOAD: state_nx = XFER;
      XFER: if (wr_rem == '0) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load = 1'b0;
    done = 1'b0;
    busy = 1'b1;
    case (state)
      IDLE: busy = 1'b0;
      LOAD: load = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Reads only launch a full burst or the tail, and only into guaranteed FIFO space.
  always_comb begin
    credit = 32'(FIFO_DEPTH) - 32'(f_used) - 32'(outstanding);
    rd_len = 32'(BURST_MAX);
    if (rd_rem < rd_len) rd_len = rd_rem;
    if (credit < rd_len) rd_len = credit;
    wr_len = 32'(BURST_MAX);
    if (wr_rem < wr_len) wr_len = wr_rem;
    rd_go = state == XFER && !avs_m0_read && rd_rem != '0 &&
            (rd_len == 32'(BURST_MAX) || rd_len == rd_rem);
    wr_go = state == XFER && !avs_m1_write && wr_rem != '0 && 32'(f_used) >= wr_len;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      {enable, irq_en, clr_pend, overflow, irq_pending} <= '0;
      {src_begin, src_end, dst_base, done_count, bytes_done} <= '0;
      avs_s0_readdata <= '0;
    end else begin
      if (clr_now) clr_pend <= 1'b0;
      if (avs_s0_write) begin
        case (avs_s0_address)
          3'd0: begin
            enable <= avs_s0_writedata[0];
            irq_en <= avs_s0_writedata[1];
            if (avs_s0_writedata[2]) clr_pend <= 1'b1;
          end
          3'd1: src_begin <= avs_s0_writedata;
          3'd2: src_end   <= avs_s0_writedata;
          3'd3: dst_base  <= avs_s0_writedata;
          default: ;
        endcase
      end
      if (clr_now) overflow <= 1'b0;
      else if (push_req && q_full && !pop) overflow <= 1'b1;
      // a completion in the same cycle as a software clear keeps the flag set
      if (done) irq_pending <= 1'b1;
      else if (clr_now || (avs_s0_write && avs_s0_address == 3'd4 && avs_s0_writedata[11]))
        irq_pending <= 1'b0;
      if (clr_now) begin
        done_count <= '0;
        bytes_done <= '0;
      end else if (done) begin
        done_count <= done_count + 32'd1;
        bytes_done <= bytes_done + (cur_beats << SH);
      end
      if (avs_s0_read) begin
        case (avs_s0_address)
          3'd0: avs_s0_readdata <= {30'd0, irq_en, enable};
          3'd1: avs_s0_readdata <= src_begin;
          3'd2: avs_s0_readdata <= src_end;
          3'd3: avs_s0_readdata <= dst_base;
          3'd4: avs_s0_readdata <= {20'd0, irq_pending, overflow, q_full, busy,
                                    4'(q_cnt), 2'd0, state};
          3'd5: avs_s0_readdata <= done_count;
          3'd6: avs_s0_readdata <= bytes_done;
          default: avs_s0_readdata <= '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_mem[q_wp] <= '{src: src_begin, lim: avs_s0_writedata, dst: dst_base};
    if (rvalid) f_mem[f_wp] <= avs_m0_readdata;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr_now) begin
      q_wp <= '0;
      q_rp <= '0;
      q_cnt <= '0;
    end else begin
      if (push) q_wp <= q_wp + 1'b1;
      if (pop)  q_rp <= q_rp + 1'b1;
      q_cnt <= q_cnt + QW'(push) - QW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      {avs_m0_read, avs_m1_write} <= '0;
      {avs_m0_address, avs_m1_address} <= '0;
      {avs_m0_burstcount, avs_m1_burstcount} <= '0;
      {cur_beats, rd_rem, wr_rem, wr_left} <= '0;
      {f_wp, f_rp, f_used, outstanding} <= '0;
    end else begin
      if (load) begin
        cur_beats      <= beats;
        rd_rem         <= beats;
        wr_rem         <= beats;
        avs_m0_address <= ADDR_W'(head.src);
        avs_m1_address <= ADDR_W'(head.dst);
      end
      if (rd_acc) begin
        avs_m0_read    <= 1'b0;
        avs_m0_address <= avs_m0_address + (ADDR_W'(avs_m0_burstcount) << SH);
        rd_rem         <= rd_rem - 32'(avs_m0_burstcount);
      end else if (rd_go) begin
        avs_m0_read       <= 1'b1;
        avs_m0_burstcount <= 16'(rd_len);
      end
      outstanding <= outstanding + (rd_acc ? FW'(avs_m0_burstcount) : FW'(0)) - FW'(rvalid);
      if (wr_go) begin
        avs_m1_write      <= 1'b1;
        avs_m1_burstcount <= 16'(wr_len);
        wr_left           <= wr_len;
      end
      if (wr_beat) begin
        wr_rem  <= wr_rem - 32'd1;
        wr_left <= wr_left - 32'd1;
        if (wr_left == 32'd1) begin
          avs_m1_write   <= 1'b0;
          avs_m1_address <= avs_m1_address + (ADDR_W'(avs_m1_burstcount) << SH);
        end
      end
      if (rvalid)  f_wp <= f_wp + 1'b1;
      if (wr_beat) f_rp <= f_rp + 1'b1;
      f_used <= f_used + FW'(rvalid) - FW'(wr_beat);
    end
  end
endmodule
